// File: rtl/tc_event_ctr.sv
// Terminal-count event counter: counts rising edges of tc, raises a sticky irq
// every `limit` events and flags a sticky overrun when irq is not acknowledged in time.
module tc_event_ctr #(
  parameter int unsigned CNT_W   = 8,
  parameter bit          TC_SYNC = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tc,
  input  logic [CNT_W-1:0] limit,
  input  logic             clear,
  input  logic             ack,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             irq,
  output logic             ovf,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2,
    OVR   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_irq, w_irq_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_tc_d;
  logic             w_tc;
  logic             w_evt;
  logic             w_term;

  generate
    if (TC_SYNC) begin : g_sync
      logic [1:0] r_sync;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= '0;
        else        r_sync <= {r_sync[0], tc};
      end
      assign w_tc = r_sync[1];
    end else begin : g_nosync
      assign w_tc = tc;
    end
  endgenerate

  // Edge register tracks tc unconditionally so a tc held across en/clear counts once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_tc_d <= 1'b0;
    else        r_tc_d <= w_tc;
  end

  assign w_evt     = en & w_tc & ~r_tc_d;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // limit-1 wraps to all-ones for limit==0, giving a 2^CNT_W period.
  assign w_term    = w_evt && (r_cnt == limit - CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_irq_nxt   = r_irq;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_cnt_nxt   = '0;
      w_irq_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = en ? COUNT : IDLE;
    end else begin
      if (r_state != IDLE && w_evt)
        w_cnt_nxt = w_term ? '0 : w_cnt_inc;
      case (r_state)
        IDLE: begin
          if (en) w_state_nxt = COUNT;
        end
        COUNT: begin
          if (w_term) begin
            w_irq_nxt   = 1'b1;
            w_state_nxt = PEND;
          end
        end
        PEND: begin
          // A terminal event coinciding with ack keeps the interrupt pending.
          if (w_term && !ack) begin
            w_ovf_nxt   = 1'b1;
            w_state_nxt = OVR;
          end else if (ack && !w_term) begin
            w_irq_nxt   = 1'b0;
            w_state_nxt = COUNT;
          end
        end
        OVR: begin
          if (ack && !w_term) begin
            w_irq_nxt   = 1'b0;
            w_state_nxt = COUNT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= w_irq_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign evt_cnt = r_cnt;
  assign irq     = r_irq;
  assign ovf     = r_ovf;
  assign state   = r_state;

endmodule

// File: tb/tb_tc_event_ctr.sv
// Self-checking bench for tc_event_ctr: event-level model compared every cycle
// against a direct-tc instance and a synchronized-tc instance, plus literal checkpoints.
module tb_tc_event_ctr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       tc = 1'b0;
  logic [7:0] limit = 8'd0;
  logic       clear = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] evt_cnt, evt_cnt_s;
  logic       irq, irq_s, ovf, ovf_s;
  logic [1:0] state, state_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tc_event_ctr #(.CNT_W(8), .TC_SYNC(1'b0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .tc(tc), .limit(limit), .clear(clear),
    .ack(ack), .evt_cnt(evt_cnt), .irq(irq), .ovf(ovf), .state(state)
  );

  tc_event_ctr #(.CNT_W(8), .TC_SYNC(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .en(en), .tc(tc), .limit(limit), .clear(clear),
    .ack(ack), .evt_cnt(evt_cnt_s), .irq(irq_s), .ovf(ovf_s), .state(state_s)
  );

  typedef struct {
    int cnt;
    bit irq;
    bit ovf;
    int st;
    bit tcp;
  } m_t;

  m_t m0, m1;
  bit d1, d2;

  // Event-level rules: an event is a new rising edge of tc while enabled;
  // the terminal event is the one that makes the running count reach limit (mod 256).
  function automatic m_t mstep(m_t m, bit e, bit t, int lim, bit clr, bit a);
    m_t  n = m;
    bit  evt = e && t && !m.tcp;
    bit  term = evt && (((m.cnt + 1) % 256) == lim);
    n.tcp = t;
    if (clr) begin
      n.cnt = 0; n.irq = 0; n.ovf = 0; n.st = e ? 1 : 0;
      return n;
    end
    if (m.st == 0) begin
      if (e) n.st = 1;
      return n;
    end
    if (evt) n.cnt = term ? 0 : (m.cnt + 1) % 256;
    if (m.st == 1 && term) begin
      n.irq = 1; n.st = 2;
    end else if (m.st == 2) begin
      if (term && !a) begin n.ovf = 1; n.st = 3; end
      else if (a && !term) begin n.irq = 0; n.st = 1; end
    end else if (m.st == 3) begin
      if (a && !term) begin n.irq = 0; n.st = 1; end
    end
    return n;
  endfunction

  function automatic m_t mzero();
    m_t z;
    z.cnt = 0; z.irq = 0; z.ovf = 0; z.st = 0; z.tcp = 0;
    return z;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0 = mzero(); m1 = mzero(); d1 = 0; d2 = 0;
    end else begin
      m0 = mstep(m0, en, tc, int'(limit), clear, ack);
      m1 = mstep(m1, en, d2, int'(limit), clear, ack);
      d2 = d1;
      d1 = tc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cnt",     int'(evt_cnt),   m0.cnt);
    chk("irq",     int'(irq),       int'(m0.irq));
    chk("ovf",     int'(ovf),       int'(m0.ovf));
    chk("state",   int'(state),     m0.st);
    chk("cnt_s",   int'(evt_cnt_s), m1.cnt);
    chk("irq_s",   int'(irq_s),     int'(m1.irq));
    chk("ovf_s",   int'(ovf_s),     int'(m1.ovf));
    chk("state_s", int'(state_s),   m1.st);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    tc = 1'b1; tick(1);
    tc = 1'b0; tick(1);
  endtask

  initial begin
    #72 reset = 1'b1;
    tick(1);
    chk("lit_reset_cnt", int'(evt_cnt), 0);
    chk("lit_reset_state", int'(state), 0);

    // en low: tc pulses every 256 cycles are ignored
    for (int i = 0; i < 2; i++) begin
      tc = 1'b1; tick(1);
      tc = 1'b0; tick(255);
    end
    chk("lit_idle_cnt", int'(evt_cnt), 0);
    chk("lit_idle_irq", int'(irq), 0);
    chk("lit_idle_state", int'(state), 0);

    // basic count, limit 3
    en = 1'b1; limit = 8'd3;
    tick(1);
    chk("lit_count_state", int'(state), 1);
    pulse(); chk("lit_cnt1", int'(evt_cnt), 1);
    pulse(); chk("lit_cnt2", int'(evt_cnt), 2);
    pulse();
    chk("lit_cnt_wrap", int'(evt_cnt), 0);
    chk("lit_irq_set", int'(irq), 1);
    chk("lit_pend", int'(state), 2);

    // held tc counts once, then ack
    tc = 1'b1; tick(5);
    tc = 1'b0; tick(1);
    chk("lit_held_cnt", int'(evt_cnt), 1);
    ack = 1'b1; tick(1);
    ack = 1'b0;
    chk("lit_ack_irq", int'(irq), 0);
    chk("lit_ack_state", int'(state), 1);

    // overrun, limit 2
    clear = 1'b1; tick(1); clear = 1'b0;
    limit = 8'd2;
    pulse(); pulse();
    chk("lit_ovr_irq", int'(irq), 1);
    chk("lit_ovr_ovf0", int'(ovf), 0);
    pulse(); pulse();
    chk("lit_ovr_ovf", int'(ovf), 1);
    chk("lit_ovr_state", int'(state), 3);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("lit_ovr_ack_irq", int'(irq), 0);
    chk("lit_ovr_ack_ovf", int'(ovf), 1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("lit_clr_ovf", int'(ovf), 0);
    chk("lit_clr_cnt", int'(evt_cnt), 0);

    // simultaneous ack and terminal event, limit 1
    limit = 8'd1;
    pulse();
    chk("lit_l1_irq", int'(irq), 1);
    chk("lit_l1_cnt", int'(evt_cnt), 0);
    tc = 1'b1; ack = 1'b1; tick(1);
    tc = 1'b0; ack = 1'b0;
    chk("lit_sim_irq", int'(irq), 1);
    chk("lit_sim_ovf", int'(ovf), 0);
    chk("lit_sim_state", int'(state), 2);
    tick(1);
    clear = 1'b1; tc = 1'b1; tick(1);
    clear = 1'b0; tc = 1'b0;
    chk("lit_clrtc_cnt", int'(evt_cnt), 0);
    chk("lit_clrtc_irq", int'(irq), 0);
    tick(1);

    // build evt_cnt=5 with irq pending, then asynchronous reset between edges
    limit = 8'd2;
    pulse(); pulse();
    limit = 8'd8;
    repeat (5) pulse();
    chk("lit_pre_rst_cnt", int'(evt_cnt), 5);
    chk("lit_pre_rst_irq", int'(irq), 1);
    #1 reset = 1'b0;
    #1;
    chk("lit_async_cnt", int'(evt_cnt), 0);
    chk("lit_async_irq", int'(irq), 0);
    chk("lit_async_state", int'(state), 0);
    tick(1);
    reset = 1'b1;

    // limit 0: 256 events per irq
    limit = 8'd0;
    tick(1);
    repeat (255) pulse();
    chk("lit_l0_cnt255", int'(evt_cnt), 255);
    chk("lit_l0_noirq", int'(irq), 0);
    pulse();
    chk("lit_l0_wrap", int'(evt_cnt), 0);
    chk("lit_l0_irq", int'(irq), 1);
    tick(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tc_event_ctr.md
Name: tc_event_ctr

Overview:
- Downstream consumer of the 8-bit free-running counter's terminal-count output `tc`.
- Counts `tc` events and raises a sticky `irq` once every `limit` events; `irq` is cleared by `ack`.
- Flags a sticky overrun (`ovf`) if a new `irq` condition occurs before the previous one is acknowledged.
- Provides the slow-timebase event and interrupt stage for the counter chain.

Parameters:
- CNT_W, 8, width of the event counter and of `limit`.
- TC_SYNC, 0, 1 = pass `tc` through a 2-flop synchronizer before edge detection (adds 2 cycles latency); 0 = `tc` is used directly (same clock domain).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- en  in  1  count enable; `tc` edges are ignored while low.
- tc  in  1  terminal count from the upstream counter; nominally a 1-cycle pulse, may be held high.
- limit  in  CNT_W  events per `irq`; sampled when an event occurs; value 0 means 2^CNT_W.
- clear  in  1  synchronous clear of count, `irq` and `ovf`.
- ack  in  1  interrupt acknowledge; clears `irq`.
- evt_cnt  out  CNT_W  events counted since the last wrap.
- irq  out  1  sticky interrupt.
- ovf  out  1  sticky overrun flag.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - evt_cnt = 0, irq = 0, ovf = 0, state = IDLE.
  - tc edge register = 0.
  - Takes effect mid-operation without waiting for a clock edge.
- Edge detect:
  - tc_d is the registered `tc`; evt = en & tc & ~tc_d.
  - A `tc` held high for N cycles counts once.
  - tc_d always updates, even when en=0 or clear=1.
- Latency:
  - TC_SYNC=0: `tc` sampled high at edge k → evt_cnt updated after edge k.
  - TC_SYNC=1: add 2 cycles.
- FSM encoding: IDLE=0, COUNT=1, PEND=2, OVR=3.
  - IDLE: en=1 → COUNT. No counting in the transition cycle.
  - COUNT: evt and evt_cnt == limit-1 (mod 2^CNT_W) → evt_cnt = 0, irq = 1, go to PEND. Otherwise evt increments evt_cnt.
  - PEND: counting continues.
    - A terminal event with no ack in the same cycle → ovf = 1, go to OVR, irq stays 1.
    - ack without a terminal event → irq = 0, go to COUNT.
    - ack and a terminal event in the same cycle → irq stays 1, stay in PEND, ovf unchanged (the new event wins).
  - OVR: counting continues; irq and ovf stay 1.
    - ack → irq = 0, go to COUNT; ovf stays 1.
    - ovf is cleared only by clear or reset.
  - en=0 in COUNT, PEND or OVR:
    - Counting freezes; evt_cnt, irq and ovf hold.
    - State is retained.
    - ack is still honoured.
- clear (highest priority after reset):
  - Next edge: evt_cnt = 0, irq = 0, ovf = 0.
  - State → COUNT if en=1, else IDLE.
  - Overrides a simultaneous evt and ack.
- Width rules:
  - evt_cnt wraps modulo 2^CNT_W.
  - limit=1: every event raises irq and evt_cnt stays 0.
  - limit=0: wrap at 2^CNT_W.
  - If limit is lowered below the current evt_cnt, evt_cnt counts up through 2^CNT_W-1, wraps to 0 without raising irq, and continues until it reaches limit-1.

Test Plan:
- Reset/idle: reset=0 for 70 ns, then reset=1, en=0, tc pulses every 2560 ns (10 ns clock, 256-cycle period) → evt_cnt=0, irq=0, state=IDLE throughout.
- Basic count: en=1, limit=3, three 1-cycle tc pulses → evt_cnt 1, 2, then 0 with irq=1 one cycle after the third pulse; state=PEND.
- Held tc and ack: tc high for 5 cycles → one increment only; then ack=1 one cycle → irq=0, state=COUNT.
- Overrun: limit=2, four tc pulses, no ack → irq=1 after the 2nd pulse; ovf=1, state=OVR after the 4th. ack → irq=0, ovf remains 1. clear → ovf=0, evt_cnt=0.
- Simultaneous events: PEND with limit=1, ack and tc edge in the same cycle → irq stays 1, ovf=0. clear and tc in the same cycle → evt_cnt=0, irq=0.
- Async reset mid-run: evt_cnt=5, irq=1, drive reset=0 between clock edges → all outputs 0 immediately. limit=0: 256 events → exactly one irq, with evt_cnt wrapping 255→0.
